// File: rtl/grf_wb_sink.sv
// General register file: synchronous write from the W-stage write-back mux, two async read ports for D.
// Define GRF_BYPASS_EN to forward the in-flight W-stage write onto RD1/RD2 within the same cycle.
module grf_wb_sink #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              WE,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic              w_wr_en;

  // $0 is excluded here so it can only ever hold the reset value
  assign w_wr_en = WE && (A3 != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[A3] <= WD;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              byp_ok
  );
    logic [DATA_W-1:0] val;
    val = stored;
`ifdef GRF_BYPASS_EN
    if (byp_ok && (addr == A3)) val = WD;
`else
    if (byp_ok && (addr == A3)) val = stored;
`endif
    if (addr == '0) val = '0;
    return val;
  endfunction

  logic w_byp_ok;
  assign w_byp_ok = !reset && w_wr_en;

  always_comb begin
    RD1 = read_port(A1, r_regs[A1], w_byp_ok);
    RD2 = read_port(A2, r_regs[A2], w_byp_ok);
  end

endmodule

// File: doc/grf_wb_sink.md
Name: grf_wb_sink

Overview:
- General register file (GRF) for the 5-stage pipeline.
- Write port is the receiving end of the W-stage write-back data mux: it consumes the selected write data (ALU result, DM read data or PC+8) plus the destination register number from W.
- Two asynchronous read ports feed the D stage.
- Synchronous write on clk; $0 hardwired to zero; optional internal W→D bypass.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; register count = 2**ADDR_W (32).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all registers on the rising edge where asserted.
- WE  input  1  write enable from W stage (instruction writes a GRF register).
- A1  input  ADDR_W  read port 1 register index (rs, D stage).
- A2  input  ADDR_W  read port 2 register index (rt, D stage).
- A3  input  ADDR_W  write register index from W stage (rd / rt / 31 after write-register select).
- WD  input  DATA_W  write data, already selected by the write-back mux.
- RD1  output  DATA_W  read data for A1.
- RD2  output  DATA_W  read data for A2.

Behaviour:
- Storage: array of 2**ADDR_W registers, DATA_W bits each.
- Reset:
  - Synchronous, active-high.
  - On the rising edge with reset=1, every register is set to 0, including $0.
  - Any write in that cycle is discarded; reset wins over WE.
  - Reset mid-stream (reset pulsed between writes) clears previously written values.
  - Deasserting reset needs no recovery cycle; a write on the first edge after reset=0 takes effect.
- Write:
  - On the rising edge with reset=0, WE=1 and A3!=0: reg[A3] <= WD.
  - A3=0 is never written; reg[0] stays 0 permanently.
  - WE=0: no register changes, regardless of A3/WD.
- Read:
  - Combinational, zero latency.
  - RD1 = (A1==0) ? 0 : reg[A1]; RD2 likewise for A2.
  - After reset, all reads return 0 until written.
- Write-then-read latency:
  - Without bypass, a value written at edge N is visible on RD1/RD2 immediately after edge N.
  - Same-cycle read of A3 before the edge returns the old value.
- Simultaneous events:
  - A1==A2: both ports return identical data.
  - A1==A3 or A2==A3 with WE=1 in the same cycle: governed by the optional feature below.
  - Any single write or read never affects other indices.
- Width rules:
  - WD is stored verbatim; no sign/zero extension inside this block.
  - The index width exactly spans the register count, so no out-of-range index exists.

Optional Feature:
- Macro: GRF_BYPASS_EN.
- Defined (internal W→D forwarding): when reset=0, WE=1, A3!=0 and A1==A3, RD1 = WD combinationally in that cycle. RD2 likewise for A2==A3. $0 is never bypassed.
  - Removes the need for a W→D forwarding mux outside the GRF.
- Undefined: RD1/RD2 always reflect stored register contents only. The pipeline must provide W→D forwarding externally.
- When reset=1, no bypass in either build; reads show stored contents.

Test Plan:
- Reset clears all: write 0xDEADBEEF to $5, assert reset 1 cycle, A1=5 → RD1=0x00000000; all 32 indices read 0.
- $0 immutable: WE=1, A3=0, WD=0x12345678, clock; A1=0 → RD1=0; with GRF_BYPASS_EN and A1=0, A3=0 same cycle → RD1=0.
- Write/readback: write $8=0x00003010, $31=0x0000300C (PC+8 case), clock; A1=8, A2=31 → RD1=0x00003010, RD2=0x0000300C; WE=0, WD=0xFFFFFFFF, A3=8, clock → $8 unchanged.
- Same-cycle read/write: $9 holds 0x11111111; WE=1, A3=9, WD=0x22222222, A1=A2=9 before edge → RD1=RD2=0x22222222 with GRF_BYPASS_EN, 0x11111111 without; after edge both builds read 0x22222222.
- Reset vs write collision: reset=1, WE=1, A3=3, WD=0xAAAAAAAA, clock; deassert reset → RD of $3 = 0; next edge write 0x55555555 to $3 → reads 0x55555555.
- Random sweep: 1000 random WE/A1/A2/A3/WD cycles against a reference array model, in both macro builds → no mismatch on RD1/RD2.
